viterbi_ctrl: RTL
=================

Name: viterbi_ctrl

Overview:
Sequencing controller for the K=3 Viterbi decoder datapath. It accepts received symbol pairs over a valid/ready handshake and registers each pair into the BMC bank. It pulses the ACS stage and writes survivor memory at a wrapping address. It issues traceback requests every TB_DEPTH symbols and at end of frame, and requests path-metric init and normalization.

Parameters:
TB_DEPTH, 16, symbols per traceback block (max tb_len)
MEM_DEPTH, 64, survivor memory entries; power of 2, constraint MEM_DEPTH >= 2*TB_DEPTH
ADDR_W, $clog2(MEM_DEPTH), survivor address width
LEN_W, $clog2(TB_DEPTH+1), tb_len width

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
start  in  1  begin frame; ignored unless IDLE
rx_valid  in  1  symbol pair valid
rx_pair  in  2  received coded pair
rx_last  in  1  qualifies final symbol of frame
rx_ready  out  1  controller accepts pair this cycle
bmc_pair  out  2  registered pair driving all bmc0..bmc7 rx_pair inputs
acs_en  out  1  ACS update strobe, one per accepted symbol
pm_init  out  1  load path metrics (state 0 = 0, others = max)
pm_msb_any  in  1  any path metric MSB set
pm_norm  out  1  subtract-normalize path metrics with this acs_en
sm_we  out  1  survivor memory write enable
sm_addr  out  ADDR_W  survivor write address
tb_start  out  1  traceback request pulse
tb_addr  out  ADDR_W  address of newest survivor word for traceback
tb_len  out  LEN_W  symbols to trace back (1..TB_DEPTH)
tb_busy  in  1  traceback unit busy
frame_done  out  1  one-cycle pulse, frame fully handed to traceback
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE, all outputs 0, sm_addr=0, block count=0, last flag=0. Reset mid-frame aborts immediately, with no tb_start or frame_done.
- States: IDLE, INIT, RUN, TB_ISSUE, DRAIN.
- IDLE: rx_ready=0. On start=1, go to INIT.
- INIT (1 cycle): pm_init=1, sm_addr<=0, blk_cnt<=0. Then go to RUN.
- RUN: rx_ready=1. Accept when rx_valid&rx_ready (cycle A): bmc_pair<=rx_pair.
- Write pipeline, cycle A+1: acs_en=1, sm_we=1 at the current sm_addr. sm_addr increments after the write, wrapping MEM_DEPTH-1 -> 0. Latency from accept to write is exactly 1 cycle; throughput is 1 symbol/cycle.
- blk_cnt increments on accept. If the accepted symbol makes blk_cnt==TB_DEPTH, or rx_last=1: go to TB_ISSUE at A+1 and latch last_q=rx_last.
- TB_ISSUE: rx_ready=0. Its first cycle is the pending write cycle.
- From the second cycle on, the first cycle with tb_busy=0 pulses tb_start. That cycle also sets tb_addr = last written address and tb_len = blk_cnt, and clears blk_cnt.
- Minimum 2 bubble cycles per block. tb_busy held high stalls indefinitely with no extra acs_en or sm_we.
- After tb_start: go to RUN if last_q=0, else DRAIN.
- DRAIN: wait for tb_busy=0 (sampled the cycle after tb_start), then pulse frame_done and go to IDLE.
- Only one traceback is outstanding at a time. Together with MEM_DEPTH >= 2*TB_DEPTH, this guarantees writes never overwrite the block being traced.
- pm_norm = acs_en & pm_msb_any_q, where pm_msb_any_q is registered from the previous cycle. pm_norm is never asserted without acs_en.
- rx_last on a block-completing symbol yields a single traceback with tb_len=TB_DEPTH.
- start while busy is ignored. rx_valid outside RUN is ignored and not consumed.
- tb_addr and tb_len hold their values between tb_start pulses.

Decomposition:
- Package viterbi_pkg holds:
  - ctrl_state_t enum (IDLE, INIT, RUN, TB_ISSUE, DRAIN)
  - default TB_DEPTH and MEM_DEPTH constants
  - the pm_init metric encoding constants shared with the ACS
- One natural sub-module: sm_addr_gen. It contains the wrapping write-address counter plus the blk_cnt counter, with clear/increment inputs and outputs last_addr and blk_cnt.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0, busy=0; start -> one pm_init pulse, rx_ready=1 the next cycle.
- 16 back-to-back symbols, tb_busy=0 -> 16 acs_en/sm_we with sm_addr 0..15; tb_start with tb_addr=15, tb_len=16; rx_ready low exactly 2 cycles.
- tb_busy high for 10 cycles when block 2 completes -> rx_ready low, no sm_we; tb_start (tb_addr=31, tb_len=16) on the first cycle tb_busy=0.
- 21-symbol frame, rx_last on symbol 21 -> tracebacks (15,16) then (20,5); DRAIN until tb_busy=0, then frame_done pulse and IDLE.
- 70 symbols, MEM_DEPTH=64 -> sm_addr wraps 63->0; 4th tb_addr=63, then writes resume at 0; rx_last on symbol 70 -> tb_addr=5, tb_len=6.
- pm_msb_any high during symbol 5 -> pm_norm coincides with the next acs_en; rst asserted mid-RUN -> all outputs 0 next cycle, no tb_start or frame_done.

Source files
------------

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared state encoding and constants for the K=3 Viterbi control path
package viterbi_pkg;

    localparam int TB_DEPTH_DEF  = 16;
    localparam int MEM_DEPTH_DEF = 64;

    // Path-metric load values used by the ACS on pm_init: state 0 starts at zero, the rest at max.
    localparam int              PM_W         = 8;
    localparam logic [PM_W-1:0] PM_INIT_ZERO = '0;
    localparam logic [PM_W-1:0] PM_INIT_MAX  = {1'b0, {(PM_W-1){1'b1}}};

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INIT     = 3'd1;
    localparam logic [2:0] ST_RUN      = 3'd2;
    localparam logic [2:0] ST_TB_ISSUE = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        INIT     = ST_INIT,
        RUN      = ST_RUN,
        TB_ISSUE = ST_TB_ISSUE,
        DRAIN    = ST_DRAIN
    } ctrl_state_t;

endpackage

// File: rtl/viterbi_ctrl_sm_addr_gen.sv
// rtl/viterbi_ctrl_sm_addr_gen.sv - wrapping survivor write address and per-block symbol counter
module sm_addr_gen
    import viterbi_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_W    = $clog2(MEM_DEPTH),
    parameter int LEN_W     = $clog2(TB_DEPTH_DEF + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              addr_inc,
    input  logic              blk_inc,
    input  logic              blk_clr,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] last_addr,
    output logic [LEN_W-1:0]  blk_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MEM_DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            addr    <= '0;
            blk_cnt <= '0;
        end else begin
            if (addr_inc)
                addr <= (addr == ADDR_MAX) ? '0 : addr + 1'b1;
            if (blk_clr)
                blk_cnt <= '0;
            else if (blk_inc)
                blk_cnt <= blk_cnt + 1'b1;
        end
    end

    // addr already points past the newest word once its write has retired
    assign last_addr = (addr == '0) ? ADDR_MAX : addr - 1'b1;

endmodule

// File: rtl/viterbi_ctrl.sv
// rtl/viterbi_ctrl.sv - symbol intake, ACS/survivor write sequencing and traceback issue for the Viterbi decoder
module viterbi_ctrl
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH  = TB_DEPTH_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_W    = $clog2(MEM_DEPTH),
    parameter int LEN_W     = $clog2(TB_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [1:0]        rx_pair,
    input  logic              rx_last,
    output logic              rx_ready,
    output logic [1:0]        bmc_pair,
    output logic              acs_en,
    output logic              pm_init,
    input  logic              pm_msb_any,
    output logic              pm_norm,
    output logic              sm_we,
    output logic [ADDR_W-1:0] sm_addr,
    output logic              tb_start,
    output logic [ADDR_W-1:0] tb_addr,
    output logic [LEN_W-1:0]  tb_len,
    input  logic              tb_busy,
    output logic              frame_done,
    output logic              busy
);

    ctrl_state_t       state, state_nx;
    logic              wr_pend, last_q, pm_msb_any_q;
    logic [1:0]        pair_q;
    logic [ADDR_W-1:0] last_addr, tb_addr_q;
    logic [LEN_W-1:0]  blk_cnt, tb_len_q;
    logic              accept, blk_end, tb_fire;

    assign rx_ready = (state == RUN);
    assign accept   = rx_valid & rx_ready;
    assign blk_end  = accept && (blk_cnt == LEN_W'(TB_DEPTH - 1) || rx_last);
    // wr_pend is only low in TB_ISSUE once the block's final write has retired
    assign tb_fire  = (state == TB_ISSUE) && !wr_pend && !tb_busy;

    assign bmc_pair   = pair_q;
    assign acs_en     = wr_pend;
    assign sm_we      = wr_pend;
    assign pm_norm    = wr_pend & pm_msb_any_q;
    assign pm_init    = (state == INIT);
    assign tb_start   = tb_fire;
    assign tb_addr    = tb_fire ? last_addr : tb_addr_q;
    assign tb_len     = tb_fire ? blk_cnt : tb_len_q;
    assign frame_done = (state == DRAIN) && !tb_busy;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = INIT;
            INIT:     state_nx = RUN;
            RUN:      if (blk_end) state_nx = TB_ISSUE;
            TB_ISSUE: if (tb_fire) state_nx = last_q ? DRAIN : RUN;
            DRAIN:    if (!tb_busy) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_pend      <= 1'b0;
            last_q       <= 1'b0;
            pm_msb_any_q <= 1'b0;
            pair_q       <= '0;
            tb_addr_q    <= '0;
            tb_len_q     <= '0;
        end else begin
            state        <= state_nx;
            wr_pend      <= accept;
            pm_msb_any_q <= pm_msb_any;
            if (accept)
                pair_q <= rx_pair;
            if (state == INIT)
                last_q <= 1'b0;
            else if (blk_end)
                last_q <= rx_last;
            if (tb_fire) begin
                tb_addr_q <= last_addr;
                tb_len_q  <= blk_cnt;
            end
        end
    end

    sm_addr_gen #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W)
    ) u_sm_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == INIT),
        .addr_inc  (wr_pend),
        .blk_inc   (accept),
        .blk_clr   (tb_fire),
        .addr      (sm_addr),
        .last_addr (last_addr),
        .blk_cnt   (blk_cnt)
    );

endmodule
